memory: RTL and testbench
=========================

# memory

Unified instruction/data RAM at the far end of the core's ImemPort and DmemPort. It answers instruction fetches and load/store accesses with one-cycle synchronous reads. A streaming load port fills the RAM with the program image after reset. The system top holds the core in reset until `ld_done` is high.

## Interface
Parameters:
- `DEPTH`, 16384: number of 32-bit words. Must be a power of two.
- `AW`, $clog2(DEPTH): word-index width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset. Synchronous and active-high.
- `addr_i`  in  `WORD_LEN`  instruction byte address from the core.
- `inst`  out  `WORD_LEN`  fetched instruction, registered.
- `addr_d`  in  `WORD_LEN`  data byte address from the core.
- `rdata`  out  `WORD_LEN`  load data, registered.
- `wen`  in  1  store strobe from the core.
- `wdata`  in  `WORD_LEN`  store data.
- `ld_valid`  in  1  loader beat valid.
- `ld_ready`  out  1  loader beat accepted when `ld_valid & ld_ready`.
- `ld_data`  in  `WORD_LEN`  loader word.
- `ld_last`  in  1  marks the final loader beat.
- `ld_done`  out  1  image loaded; the core may run.
- `fault`  out  1  sticky out-of-range flag. Present only with `MEM_BOUNDS_CHECK_EN`.

## Operation
- Storage: `DEPTH` x 32 array. RAM contents are not cleared by reset.
- Word index for either port is `addr[AW+1:2]`.
  - `addr[1:0]` is ignored, so misaligned accesses act as aligned.
  - Upper address bits are handled per Configuration.
- Reads: both ports are read every cycle.
  - `inst <= mem[idx_i]`, `rdata <= mem[idx_d]`.
  - Reads are read-first: a same-cycle write to the same word returns the old data.
- Loader FSM: states `LOAD` and `DONE`; 2-bit state register; `AW`-bit write pointer `ptr`.
  - On `rst`: state=`LOAD`, `ptr`=0.
  - `LOAD`:
    - `ld_ready`=1, `ld_done`=0.
    - On each accepted beat: `mem[ptr] <= ld_data`, then `ptr <= ptr+1`.
    - If `ld_last` is set, or `ptr == DEPTH-1`, go to `DONE`.
    - Cycles with `ld_valid`=0 change nothing.
  - `DONE`:
    - `ld_ready`=0, `ld_done`=1.
    - Holds until `rst`. `ld_valid` is ignored.
  - There is no pointer wrap: a full array forces `DONE`.
- Core writes:
  - `mem[idx_d] <= wdata` when `wen`=1 and state=`DONE`.
  - `wen` in `LOAD` is ignored, so the loader never collides with the core.
- Reset mid-load: returns to `LOAD` with `ptr`=0. Words already loaded remain until overwritten.
- Reset values:
  - `inst`=0, `rdata`=0.
  - `ld_ready`=1 and `ld_done`=0 (first cycle after `rst` deasserts).
  - `fault`=0.

## Timing
- Read latency is 1 cycle: an address stable in cycle n gives data during cycle n+1.
  - This matches the core: `pc_reg` is stable from IF, so `inst` is valid in ID/EX/MEM/WB.
  - `addr_d` is stable from MEM, so `rdata` is valid in WB.
- A write commits on the edge where the strobe is sampled. A read issued the next cycle returns the new data.
- `ld_done` rises the cycle after the final beat is accepted.
- `ld_ready` and `ld_done` are decoded combinationally from the registered state and are glitch-free.
- Loader throughput: one beat per cycle.

## Configuration
- `MEM_BOUNDS_CHECK_EN` defined:
  - An access is out of range when any `addr[31:AW+2]` bit is nonzero.
  - An out-of-range core write is suppressed and sets `fault`.
  - An out-of-range read returns 0 on that port and sets `fault`.
  - `fault` is cleared only by `rst`.
- `MEM_BOUNDS_CHECK_EN` not defined:
  - The `fault` port is absent.
  - Upper address bits are ignored, so addresses wrap modulo `DEPTH*4`.

## Test plan
- Reset, then load 0x00000013, 0x00602823, 0xDEADBEEF with `ld_last` on the third beat.
  - -> `ld_done`=1 and `ld_ready`=0 one cycle after the third beat.
  - Then `addr_i`=0x4 -> `inst`=0x00602823 next cycle.
- Loader with gaps: `ld_valid` pattern 1,0,0,1,1(last) with data 0xA,0xB,0xC.
  - -> words 0..2 = 0xA,0xB,0xC.
  - `ld_done` rises only after the 0xC beat.
- After `DONE`: store with `wen`=1, `addr_d`=0x100, `wdata`=0x12345678, holding `addr_d`.
  - -> `rdata` shows the old word on the next cycle (read-first).
  - -> `rdata`=0x12345678 on the cycle after that.
- `wen`=1, `addr_d`=0x8, `wdata`=0xFFFFFFFF during `LOAD`, then finish the load with word 2 = 0x55.
  - -> read of 0x8 returns 0x55 (the core write was ignored).
- `rst` after 2 of 4 beats, then reload 0x77 as a single beat with `ld_last`.
  - -> `ld_done` stays 0 until the 0x77 beat.
  - -> word 0 = 0x77; word 1 keeps its earlier value.
- With `MEM_BOUNDS_CHECK_EN`: `wen`=1, `addr_d`=DEPTH*4, `wdata`=0x1.
  - -> `fault`=1 and stays 1; word 0 unchanged; `rdata`=0.
- Without `MEM_BOUNDS_CHECK_EN`: same stimulus -> word 0 = 0x1.

Source files
------------

// File: rtl/memory.sv
// Unified instruction/data RAM with a streaming program loader.
// Ports: clk, rst, addr_i/inst (fetch), addr_d/rdata/wen/wdata (load/store),
// ld_valid/ld_ready/ld_data/ld_last/ld_done (image loader), and fault when
// MEM_BOUNDS_CHECK_EN is defined (sticky out-of-range flag).
// Both read ports return data one cycle after the address, read-first.

`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module memory #(
    parameter int DEPTH = 16384,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [`WORD_LEN-1:0] addr_i,
    output logic [`WORD_LEN-1:0] inst,
    input  logic [`WORD_LEN-1:0] addr_d,
    output logic [`WORD_LEN-1:0] rdata,
    input  logic                 wen,
    input  logic [`WORD_LEN-1:0] wdata,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [`WORD_LEN-1:0] ld_data,
    input  logic                 ld_last,
    output logic                 ld_done
`ifdef MEM_BOUNDS_CHECK_EN
    ,
    output logic                 fault
`endif
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_DONE = 2'd1
    } state_e;

    state_e state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    logic [`WORD_LEN-1:0] mem [DEPTH];

    logic [`WORD_LEN-1:0] inst_q, inst_d;
    logic [`WORD_LEN-1:0] rdata_q, rdata_d;

    logic [AW-1:0] idx_i, idx_d;
    logic          oob_i, oob_d;

    logic                 load_fire;
    logic                 core_we;
    logic                 mem_we;
    logic [AW-1:0]        mem_waddr;
    logic [`WORD_LEN-1:0] mem_wdata;

    assign idx_i = addr_i[AW+1:2];
    assign idx_d = addr_d[AW+1:2];

`ifdef MEM_BOUNDS_CHECK_EN
    logic fault_q, fault_d;

    assign oob_i = |addr_i[`WORD_LEN-1:AW+2];
    assign oob_d = |addr_d[`WORD_LEN-1:AW+2];

    // Any out-of-range access on either port latches the flag until reset.
    always_comb begin
        fault_d = fault_q | oob_i | oob_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;

    logic unused_addr;
    assign unused_addr = ^{addr_i[1:0], addr_d[1:0]};
`else
    // Upper bits are dropped so addresses wrap modulo the array size.
    assign oob_i = 1'b0;
    assign oob_d = 1'b0;

    logic unused_addr;
    assign unused_addr = ^{addr_i[`WORD_LEN-1:AW+2], addr_i[1:0],
                           addr_d[`WORD_LEN-1:AW+2], addr_d[1:0]};
`endif

    // Loader FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Loader FSM: next state. The last array slot forces DONE so the
    // pointer never wraps onto the start of the image.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_LOAD: begin
                if (ld_valid) begin
                    ptr_d = ptr_q + AW'(1);
                    if (ld_last || ptr_q == AW'(DEPTH - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // Loader FSM: outputs, decoded straight from the state register.
    always_comb begin
        ld_ready = 1'b0;
        ld_done  = 1'b0;
        case (state_q)
            ST_LOAD: ld_ready = 1'b1;
            ST_DONE: ld_done  = 1'b1;
            default: begin
                ld_ready = 1'b0;
                ld_done  = 1'b0;
            end
        endcase
    end

    // Single write port: loader owns it in LOAD, the core in DONE.
    always_comb begin
        load_fire = ld_valid & ld_ready;
        core_we   = wen & ld_done & ~oob_d;
        mem_we    = ~rst & (load_fire | core_we);
        mem_waddr = load_fire ? ptr_q : idx_d;
        mem_wdata = load_fire ? ld_data : wdata;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read-first: the output flops capture the array before this edge's write.
    always_comb begin
        inst_d  = oob_i ? '0 : mem[idx_i];
        rdata_d = oob_d ? '0 : mem[idx_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q  <= '0;
            rdata_q <= '0;
        end else begin
            inst_q  <= inst_d;
            rdata_q <= rdata_d;
        end
    end

    assign inst  = inst_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_memory.sv
// Testbench for memory: directed scenarios plus randomized traffic,
// checked against a word-array reference model.

`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module tb_memory;

    localparam int DEPTH = 128;
    localparam int AW    = 7;
`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] addr_i;
    logic [31:0] inst;
    logic [31:0] addr_d;
    logic [31:0] rdata;
    logic        wen;
    logic [31:0] wdata;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_done;
`ifdef MEM_BOUNDS_CHECK_EN
    logic        fault;
`endif

    memory #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr_i  (addr_i),
        .inst    (inst),
        .addr_d  (addr_d),
        .rdata   (rdata),
        .wen     (wen),
        .wdata   (wdata),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_data (ld_data),
        .ld_last (ld_last),
        .ld_done (ld_done)
`ifdef MEM_BOUNDS_CHECK_EN
        ,
        .fault   (fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    bit          m_done;
    int          m_ptr;
    bit          m_fault;
    logic [31:0] e_inst;
    logic [31:0] e_rdata;
    bit          k_inst;
    bit          k_rdata;

    int checks;
    int failures;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Apply current inputs for one clock, update model, check outputs.
    task automatic tick();
        int ii;
        int id;
        bit oi;
        bit od;
        ii = int'((addr_i >> 2) % DEPTH);
        id = int'((addr_d >> 2) % DEPTH);
        oi = BC && ((addr_i >> 2) >= DEPTH);
        od = BC && ((addr_d >> 2) >= DEPTH);
        if (rst) begin
            m_done  = 1'b0;
            m_ptr   = 0;
            m_fault = 1'b0;
            e_inst  = '0;
            e_rdata = '0;
            k_inst  = 1'b1;
            k_rdata = 1'b1;
        end else begin
            if (oi) begin
                e_inst = '0;
                k_inst = 1'b1;
            end else begin
                e_inst = m_mem[ii];
                k_inst = m_known[ii];
            end
            if (od) begin
                e_rdata = '0;
                k_rdata = 1'b1;
            end else begin
                e_rdata = m_mem[id];
                k_rdata = m_known[id];
            end
            if (oi || od) m_fault = 1'b1;
            if (!m_done) begin
                if (ld_valid) begin
                    m_mem[m_ptr]   = ld_data;
                    m_known[m_ptr] = 1'b1;
                    m_ptr++;
                    if (ld_last || m_ptr == DEPTH) m_done = 1'b1;
                end
            end else if (wen && !od) begin
                m_mem[id]   = wdata;
                m_known[id] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("ld_done", {31'b0, ld_done}, {31'b0, m_done});
        check("ld_ready", {31'b0, ld_ready}, {31'b0, !m_done});
        if (k_inst) check("inst", inst, e_inst);
        if (k_rdata) check("rdata", rdata, e_rdata);
`ifdef MEM_BOUNDS_CHECK_EN
        check("fault", {31'b0, fault}, {31'b0, m_fault});
`endif
    endtask

    task automatic idle_inputs();
        rst      = 1'b0;
        addr_i   = '0;
        addr_d   = '0;
        wen      = 1'b0;
        wdata    = '0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input bit last);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_data  = $urandom;
    endtask

    task automatic rand_addr(output logic [31:0] a);
        if (BC) begin
            if ($urandom_range(0, 49) == 0) a = $urandom;
            else a = $urandom_range(0, DEPTH * 4 - 1);
        end else begin
            a = $urandom;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_known[i] = 1'b0;
            m_mem[i]   = '0;
        end
        m_done  = 1'b0;
        m_ptr   = 0;
        m_fault = 1'b0;

        // Reset state
        do_reset();
        check("rst_inst", inst, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_ready", {31'b0, ld_ready}, 32'h1);
        check("rst_done", {31'b0, ld_done}, 32'h0);

        // Basic three-word image
        beat(32'h00000013, 1'b0);
        beat(32'h00602823, 1'b0);
        check("tp_nodone", {31'b0, ld_done}, 32'h0);
        beat(32'hDEADBEEF, 1'b1);
        check("tp_done", {31'b0, ld_done}, 32'h1);
        check("tp_ready", {31'b0, ld_ready}, 32'h0);
        addr_i = 32'h4;
        tick();
        check("tp_inst", inst, 32'h00602823);

        // Loader with gaps
        do_reset();
        beat(32'hA, 1'b0);
        tick();
        check("gap_nodone1", {31'b0, ld_done}, 32'h0);
        tick();
        beat(32'hB, 1'b0);
        check("gap_nodone2", {31'b0, ld_done}, 32'h0);
        beat(32'hC, 1'b1);
        check("gap_done", {31'b0, ld_done}, 32'h1);
        addr_i = 32'h0;
        addr_d = 32'h4;
        tick();
        check("gap_w0", inst, 32'hA);
        check("gap_w1", rdata, 32'hB);
        addr_i = 32'h8;
        tick();
        check("gap_w2", inst, 32'hC);

        // Read-first store
        addr_d = 32'h100;
        wen    = 1'b1;
        wdata  = 32'hCAFE0000;
        tick();
        wen = 1'b0;
        tick();
        wen   = 1'b1;
        wdata = 32'h12345678;
        tick();
        check("st_old", rdata, 32'hCAFE0000);
        wen = 1'b0;
        tick();
        check("st_new", rdata, 32'h12345678);

        // Core write ignored during LOAD
        do_reset();
        addr_d = 32'h8;
        wen    = 1'b1;
        wdata  = 32'hFFFFFFFF;
        beat(32'h1, 1'b0);
        tick();
        beat(32'h2, 1'b0);
        tick();
        wen = 1'b0;
        beat(32'h55, 1'b1);
        tick();
        check("ldwen_w2", rdata, 32'h55);

        // Reset mid-load
        do_reset();
        beat(32'h11, 1'b0);
        beat(32'h22, 1'b0);
        do_reset();
        check("rml_nodone", {31'b0, ld_done}, 32'h0);
        tick();
        check("rml_nodone2", {31'b0, ld_done}, 32'h0);
        beat(32'h77, 1'b1);
        check("rml_done", {31'b0, ld_done}, 32'h1);
        addr_i = 32'h0;
        addr_d = 32'h4;
        tick();
        check("rml_w0", inst, 32'h77);
        check("rml_w1", rdata, 32'h22);

        // Out-of-range / wrapping store
        addr_d = DEPTH * 4;
        wen    = 1'b1;
        wdata  = 32'h1;
        tick();
        wen    = 1'b0;
        addr_d = 32'h0;
        tick();
`ifdef MEM_BOUNDS_CHECK_EN
        check("oob_fault", {31'b0, fault}, 32'h1);
        check("oob_w0", rdata, 32'h77);
        addr_d = DEPTH * 4;
        tick();
        check("oob_rd0", rdata, 32'h0);
        addr_d = 32'h0;
        tick();
        check("oob_sticky", {31'b0, fault}, 32'h1);
`else
        check("wrap_w0", rdata, 32'h1);
`endif

        // Full array forces DONE without ld_last
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) check("full_nodone", {31'b0, ld_done}, 32'h0);
            beat(32'(i * 3 + 1), 1'b0);
        end
        check("full_done", {31'b0, ld_done}, 32'h1);
        beat(32'hBAD0BAD0, 1'b1);
        addr_i = (DEPTH - 1) * 4;
        addr_d = 32'h0;
        tick();
        check("full_last", inst, 32'((DEPTH - 1) * 3 + 1));
        check("full_first", rdata, 32'h1);

        // Randomized traffic
        for (int it = 0; it < 6; it++) begin
            do_reset();
            for (int c = 0; c < 60 && !m_done; c++) begin
                ld_valid = ($urandom_range(0, 3) != 0);
                ld_last  = ($urandom_range(0, 11) == 0);
                ld_data  = $urandom;
                addr_i   = $urandom_range(0, DEPTH * 4 - 1);
                addr_d   = $urandom_range(0, DEPTH * 4 - 1);
                wen      = $urandom_range(0, 1);
                wdata    = $urandom;
                tick();
            end
            for (int c = 0; c < 150; c++) begin
                rand_addr(addr_i);
                rand_addr(addr_d);
                wen      = $urandom_range(0, 1);
                wdata    = $urandom;
                ld_valid = $urandom_range(0, 1);
                ld_last  = $urandom_range(0, 1);
                ld_data  = $urandom;
                tick();
            end
            idle_inputs();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
